// File: rtl/full_adder_nbit_pkg.sv
// Shared constants for the registered n-bit ripple-carry adder.
// Holds the default operand width used by full_adder_nbit.
package full_adder_nbit_pkg;

    localparam int BIT_DEFAULT = 4;

endpackage

// File: rtl/full_adder_nbit_cell.sv
// 1-bit combinational full-adder cell.
// Ports: a_i, b_i, cin_i -> s_o (sum bit), cout_o (carry out).
module full_adder (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic s_o,
    output logic cout_o
);

    logic p;

    assign p      = a_i ^ b_i;
    assign s_o    = p ^ cin_i;
    assign cout_o = (a_i & b_i) | (cin_i & p);

endmodule

// File: rtl/full_adder_nbit.sv
// Registered BIT-wide ripple-carry adder: {cout_o,sum_o} = a_i+b_i+cin_i.
// Ports: clk_i, rst_ni, valid_i, a_i, b_i, cin_i -> sum_o, cout_o, valid_o.
module full_adder_nbit
    import full_adder_nbit_pkg::*;
#(
    parameter int BIT = BIT_DEFAULT
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           valid_i,
    input  logic [BIT-1:0] a_i,
    input  logic [BIT-1:0] b_i,
    input  logic           cin_i,
    output logic [BIT-1:0] sum_o,
    output logic           cout_o,
    output logic           valid_o
);

    logic [BIT:0]   carry;
    logic [BIT-1:0] sum_d;
    logic           cout_d;
    logic [BIT-1:0] sum_q;
    logic           cout_q;
    logic           valid_q;

    assign carry[0] = cin_i;

    for (genvar k = 0; k < BIT; k++) begin : g_cell
        full_adder u_fa (
            .a_i    (a_i[k]),
            .b_i    (b_i[k]),
            .cin_i  (carry[k]),
            .s_o    (sum_d[k]),
            .cout_o (carry[k+1])
        );
    end

    assign cout_d = carry[BIT];

    // Result flops only load on valid, so operand X/Z while idle
    // never reaches the held outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sum_q   <= '0;
            cout_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_i;
            if (valid_i) begin
                sum_q  <= sum_d;
                cout_q <= cout_d;
            end
        end
    end

    assign sum_o   = sum_q;
    assign cout_o  = cout_q;
    assign valid_o = valid_q;

endmodule

// File: tb/tb_full_adder_nbit.sv
// Self-checking bench for full_adder_nbit with BIT=4.
// Arithmetic reference model plus directed literal checks.
module tb_full_adder_nbit;

    localparam int W = 4;

    logic         clk;
    logic         rst_n;
    logic         valid_i;
    logic [W-1:0] a_i;
    logic [W-1:0] b_i;
    logic         cin_i;
    logic [W-1:0] sum_o;
    logic         cout_o;
    logic         valid_o;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 0;

    logic [W:0] m_res;
    logic       m_valid;

    full_adder_nbit #(.BIT(W)) dut (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .valid_i (valid_i),
        .a_i     (a_i),
        .b_i     (b_i),
        .cin_i   (cin_i),
        .sum_o   (sum_o),
        .cout_o  (cout_o),
        .valid_o (valid_o)
    );

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference: plain integer addition, registered on valid.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_res   <= '0;
            m_valid <= 1'b0;
        end else begin
            m_valid <= valid_i;
            if (valid_i)
                m_res <= {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            checks++;
            if ({valid_o, cout_o, sum_o} !== {m_valid, m_res}) begin
                errors++;
                $display("FAIL model t=%0t: got v=%b c=%b s=%h exp v=%b c=%b s=%h",
                         $time, valid_o, cout_o, sum_o,
                         m_valid, m_res[W], m_res[W-1:0]);
            end
        end
    end

    task automatic lit(input string name, input logic [5:0] exp);
        checks++;
        if ({valid_o, cout_o, sum_o} !== exp) begin
            errors++;
            $display("FAIL %s: got v=%b c=%b s=%h exp v=%b c=%b s=%h",
                     name, valid_o, cout_o, sum_o, exp[5], exp[4], exp[3:0]);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
        @(negedge clk);
        valid_i = v;
        a_i     = a;
        b_i     = b;
        cin_i   = c;
    endtask

    task automatic step(input string name, input logic v,
                        input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic [5:0] exp);
        drive(v, a, b, c);
        @(posedge clk);
        #1;
        lit(name, exp);
    endtask

    initial begin
        rst_n   = 1;
        valid_i = 0;
        a_i     = 0;
        b_i     = 0;
        cin_i   = 0;
        #1 rst_n = 0;
        #1 lit("reset_init", 6'b0_0_0000);
        repeat (2) @(negedge clk);
        rst_n  = 1;
        cmp_en = 1;

        step("add_3_4",   1, 4'h3, 4'h4, 0, 6'b1_0_0111);
        step("carry_F_1", 1, 4'hF, 4'h1, 0, 6'b1_1_0000);
        step("carry_FF1", 1, 4'hF, 4'hF, 1, 6'b1_1_1111);
        step("cin_only",  1, 4'h0, 4'h0, 1, 6'b1_0_0001);
        step("hold_load", 1, 4'h5, 4'h6, 0, 6'b1_0_1011);
        step("hold_idle", 0, 4'h9, 4'h9, 0, 6'b0_0_1011);
        step("hold_x",    0, 4'hx, 4'hx, 1'bx, 6'b0_0_1011);
        step("max_nocin", 1, 4'hF, 4'hF, 0, 6'b1_1_1110);
        step("pair_8_8",  1, 4'h8, 4'h8, 0, 6'b1_1_0000);

        for (int i = 0; i < 16; i++) begin
            drive(1, W'($urandom_range(0, 15)),
                  W'($urandom_range(0, 15)),
                  1'($urandom_range(0, 1)));
        end
        @(posedge clk);
        #1;
        checks++;
        if (valid_o !== 1'b1) begin
            errors++;
            $display("FAIL stream_valid: got %b exp 1", valid_o);
        end

        step("pre_reset", 1, 4'hA, 4'h7, 1, 6'b1_1_0010);
        drive(1, 4'hC, 4'hC, 1);
        #2 rst_n = 0;
        #1 lit("async_rst", 6'b0_0_0000);
        @(posedge clk);
        #1 lit("rst_hold_vin", 6'b0_0_0000);
        @(negedge clk);
        rst_n = 1;
        valid_i = 0;
        @(posedge clk);
        #1 lit("post_rst_idle", 6'b0_0_0000);
        step("post_rst_add", 1, 4'h2, 4'h9, 1, 6'b1_0_1100);
        step("final_idle",   0, 4'h1, 4'h1, 0, 6'b0_0_1100);

        @(negedge clk);
        cmp_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
